// File: rtl/distortion_pkg.sv
// Shared mode encoding, fixed-point constants and saturation helper
// for the multimode distortion stage.
package distortion_pkg;

   typedef enum logic [1:0] {
      DIST_BYPASS = 2'd0,
      DIST_HARD   = 2'd1,
      DIST_SOFT   = 2'd2
   } dist_mode_e;

   localparam int GAIN_FRAC  = 4;
   localparam int SOFT_SHIFT = 2;
   // Working width for saturation; must cover DATA_WIDTH+GAIN_WIDTH+1.
   localparam int SAT_W      = 128;

   // Clamp a wide signed value into the signed range of a dw-bit word.
   function automatic logic signed [SAT_W-1:0] sat_signed(
      input logic signed [SAT_W-1:0] v,
      input int                      dw
   );
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      hi = (SAT_W'(1) << (dw - 1)) - SAT_W'(1);
      lo = ~hi;
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/dist_gain_sat.sv
// Pre-gain multiply (signed sample x unsigned Q.4 gain), rescale and
// saturate back to sample width; bypass passes the sample untouched.
module dist_gain_sat
   import distortion_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int GAIN_WIDTH = 8
) (
   input  logic signed [DATA_WIDTH-1:0] x,
   input  logic        [GAIN_WIDTH-1:0] gain,
   input  logic                         bypass,
   output logic signed [DATA_WIDTH-1:0] v,
   output logic                         sat
);

   localparam int PW = DATA_WIDTH + GAIN_WIDTH + 1;

   logic signed [PW-1:0]    xe;
   logic signed [PW-1:0]    ge;
   logic signed [PW-1:0]    p;
   logic signed [PW-1:0]    ps;
   logic signed [SAT_W-1:0] pw;
   logic signed [SAT_W-1:0] vs;

   always_comb begin
      xe = PW'(x);
      ge = $signed(PW'(gain));
      p  = xe * ge;
      ps = p >>> GAIN_FRAC;
      pw = SAT_W'(ps);
      vs = sat_signed(pw, DATA_WIDTH);
      if (bypass) begin
         v   = x;
         sat = 1'b0;
      end else begin
         v   = vs[DATA_WIDTH-1:0];
         sat = (vs != pw);
      end
   end

endmodule

// File: rtl/distortion_multimode.sv
// Three-stage distortion pipeline: capture, gain/saturate, clip shaper.
// Carries channel tags alongside samples and keeps sticky per-channel clip flags.
module distortion_multimode
   import distortion_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int GAIN_WIDTH = 8,
   parameter int NUM_CH     = 2,
   localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                         CLK,
   input  logic                         rst,
   input  logic                         en,
   input  logic                         audio_ready,
   input  logic signed [DATA_WIDTH-1:0] x,
   input  logic        [CH_W-1:0]       ch_in,
   input  logic        [1:0]            mode,
   input  logic        [GAIN_WIDTH-1:0] gain,
   input  logic        [DATA_WIDTH-2:0] thresh,
   input  logic                         clr_ind,
   output logic signed [DATA_WIDTH-1:0] y,
   output logic                         y_valid,
   output logic        [CH_W-1:0]       ch_out,
   output logic                         clip,
   output logic        [NUM_CH-1:0]     indicator
);

   localparam int DW     = DATA_WIDTH;
   localparam int STAGES = 3;

   typedef struct packed {
      logic [DW-1:0]         x;
      logic [CH_W-1:0]       ch;
      dist_mode_e            mode;
      logic [GAIN_WIDTH-1:0] gain;
      logic [DW-2:0]         thresh;
   } s1_t;

   typedef struct packed {
      logic [DW-1:0]   v;
      logic            sat;
      logic [CH_W-1:0] ch;
      dist_mode_e      mode;
      logic [DW-2:0]   thresh;
   } s2_t;

   logic [STAGES:1] vld_pipe;
   s1_t             s1;
   s2_t             s2;
   dist_mode_e      eff_mode;

   logic signed [DW-1:0]    gs_v;
   logic                    gs_sat;

   logic [DW-1:0]           thr;
   logic [DW-1:0]           mag;
   logic [DW-1:0]           lim;
   logic                    neg;
   logic                    over;
   logic signed [DW:0]      signed_res;
   logic signed [SAT_W-1:0] res_wide;
   logic signed [SAT_W-1:0] res_sat;
   logic [DW-1:0]           y_nxt;
   logic                    clip_nxt;
   logic [NUM_CH-1:0]       ind_nxt;

   // Disabled stage and the reserved mode both collapse to bypass at capture.
   assign eff_mode = (en && mode != 2'd3) ? dist_mode_e'(mode) : DIST_BYPASS;

   dist_gain_sat #(
      .DATA_WIDTH (DATA_WIDTH),
      .GAIN_WIDTH (GAIN_WIDTH)
   ) u_gain_sat (
      .x      ($signed(s1.x)),
      .gain   (s1.gain),
      .bypass (s1.mode == DIST_BYPASS),
      .v      (gs_v),
      .sat    (gs_sat)
   );

   // Magnitude of the most negative value is 2^(DW-1), which still fits unsigned.
   always_comb begin
      thr  = {1'b0, s2.thresh};
      neg  = s2.v[DW-1];
      mag  = neg ? (~s2.v + DW'(1)) : s2.v;
      over = (s2.mode != DIST_BYPASS) && (mag > thr);
      lim  = mag;
      if (over) begin
         case (s2.mode)
            DIST_HARD: lim = thr;
            DIST_SOFT: lim = thr + ((mag - thr) >> SOFT_SHIFT);
            default:   lim = mag;
         endcase
      end
      signed_res = neg ? -$signed({1'b0, lim}) : $signed({1'b0, lim});
      res_wide   = SAT_W'(signed_res);
      res_sat    = sat_signed(res_wide, DW);
      y_nxt      = res_sat[DW-1:0];
      clip_nxt   = s2.sat | over | (res_sat != res_wide);
   end

   // Set beats clear for the channel whose clipped sample is emitted this cycle.
   always_comb begin
      ind_nxt = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         ind_nxt[i] = (indicator[i] & ~clr_ind)
                    | (vld_pipe[2] & clip_nxt & (32'(s2.ch) == i));
      end
   end

   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         vld_pipe  <= '0;
         s1        <= '0;
         s2        <= '0;
         y         <= '0;
         ch_out    <= '0;
         clip      <= 1'b0;
         indicator <= '0;
      end else begin
         vld_pipe <= {vld_pipe[STAGES-1:1], audio_ready};
         if (audio_ready) begin
            s1.x      <= x;
            s1.ch     <= ch_in;
            s1.mode   <= eff_mode;
            s1.gain   <= gain;
            s1.thresh <= thresh;
         end
         if (vld_pipe[1]) begin
            s2.v      <= gs_v;
            s2.sat    <= gs_sat;
            s2.ch     <= s1.ch;
            s2.mode   <= s1.mode;
            s2.thresh <= s1.thresh;
         end
         if (vld_pipe[2]) begin
            y      <= y_nxt;
            clip   <= clip_nxt;
            ch_out <= s2.ch;
         end
         indicator <= ind_nxt;
      end
   end

   assign y_valid = vld_pipe[STAGES];

endmodule
